// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and defaults for the UART receive path (and a future transmit
// path).
//   rx_state_t           - receiver FSM state encoding
//   DEFAULT_CLKS_PER_BIT - clock cycles per serial bit (100 MHz / 115200)
//   DEFAULT_RX_DEPTH     - default receive FIFO depth in bytes
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int DEFAULT_CLKS_PER_BIT = 868;
   localparam int DEFAULT_RX_DEPTH     = 16;

endpackage

// File: rtl/fifo_sync.sv
// -----------------------------------------------------------------------------
// fifo_sync
// Single-clock first-word-fall-through FIFO, reusable for rx and tx buffers.
// Ports:
//   clk, rst - clock and synchronous active-high reset (pointers only)
//   push     - write din this cycle (honoured when not full, or when a pop
//              frees the slot in the same cycle)
//   pop      - consume the head entry (ignored when empty)
//   din      - write data
//   dout     - head entry while non-empty, zero when empty
//   empty    - no entries held
//   full     - DEPTH entries held
//   count    - number of entries held
// -----------------------------------------------------------------------------
module fifo_sync #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   // Storage is never reset; only the pointers are.
   logic [WIDTH-1:0] mem [DEPTH];

   // One extra pointer bit distinguishes full from empty when the address
   // bits coincide.
   logic [AW:0] wr_ptr_reg;
   logic [AW:0] rd_ptr_reg;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle releases the head slot, so a push into a full
   // FIFO still lands (it writes the slot the head is leaving).
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   assign count = wr_ptr_reg - rd_ptr_reg;
   assign dout  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/uart_rx_buf.sv
// -----------------------------------------------------------------------------
// uart_rx_buf
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO, with sticky
// overrun and framing-error flags.
// Ports:
//   clk       - sole clock
//   rst       - synchronous active-high reset
//   rxd       - asynchronous serial input, idle high, LSB first
//   rd_en     - pop the head byte (same-cycle consume)
//   clr_err   - clear the sticky error flags
//   rxdata    - head byte of the FIFO (zero when empty)
//   rx_valid  - FIFO holds at least one byte
//   count     - bytes currently held
//   overrun   - sticky: a received byte was dropped because the FIFO was full
//   frame_err - sticky: a frame arrived with a low stop bit
// -----------------------------------------------------------------------------
module uart_rx_buf
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DEPTH        = DEFAULT_RX_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rxd,
   input  logic                   rd_en,
   input  logic                   clr_err,
   output logic [7:0]             rxdata,
   output logic                   rx_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overrun,
   output logic                   frame_err
);

   localparam int              TW        = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0]   BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0]   HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

   // -------------------------------------------------------------------------
   // Input synchronizer; both stages reset to the idle (high) line level so
   // reset never looks like a start bit.
   // -------------------------------------------------------------------------
   logic sync1_reg;
   logic sync2_reg;
   logic rx_line;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
      end else begin
         sync1_reg <= rxd;
         sync2_reg <= sync1_reg;
      end
   end

   assign rx_line = sync2_reg;

   // -------------------------------------------------------------------------
   // Receiver FSM
   // -------------------------------------------------------------------------
   rx_state_t     state_reg,  state_next;
   logic [TW-1:0] timer_reg,  timer_next;
   logic [2:0]    index_reg,  index_next;
   logic [7:0]    shift_reg;
   logic          sample_data;
   logic          push_strobe;
   logic          frame_err_set;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         timer_reg <= '0;
         index_reg <= '0;
      end else begin
         state_reg <= state_next;
         timer_reg <= timer_next;
         index_reg <= index_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      timer_next    = timer_reg + 1'b1;
      index_next    = index_reg;
      sample_data   = 1'b0;
      push_strobe   = 1'b0;
      frame_err_set = 1'b0;
      case (state_reg)
         IDLE: begin
            timer_next = '0;
            if (!rx_line) begin
               state_next = START;
            end
         end
         START: begin
            // Mid start bit: a line back high means the falling edge was a
            // glitch, so drop it silently.
            if (timer_reg == HALF_LAST) begin
               timer_next = '0;
               index_next = '0;
               state_next = rx_line ? IDLE : DATA;
            end
         end
         DATA: begin
            if (timer_reg == BIT_LAST) begin
               timer_next  = '0;
               sample_data = 1'b1;
               // index wraps back to 0 after bit 7, ready for the next frame
               index_next  = index_reg + 1'b1;
               if (index_reg == 3'd7) begin
                  state_next = STOP;
               end
            end
         end
         STOP: begin
            // Leave at mid stop bit so the next start edge is never missed.
            if (timer_reg == BIT_LAST) begin
               timer_next    = '0;
               state_next    = IDLE;
               push_strobe   = rx_line;
               frame_err_set = !rx_line;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Each shift-register bit captures the line when its index is sampled.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_shift
         always_ff @(posedge clk) begin
            if (rst) begin
               shift_reg[gi] <= 1'b0;
            end else if (sample_data && (index_reg == 3'(gi))) begin
               shift_reg[gi] <= rx_line;
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Receive FIFO
   // -------------------------------------------------------------------------
   logic fifo_empty;
   logic fifo_full;

   fifo_sync #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_strobe),
      .pop   (rd_en),
      .din   (shift_reg),
      .dout  (rxdata),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (count)
   );

   assign rx_valid = !fifo_empty;

   // -------------------------------------------------------------------------
   // Sticky error flags; a set event in the same cycle beats clr_err.
   // -------------------------------------------------------------------------
   logic overrun_set;
   logic overrun_reg;
   logic frame_err_reg;

   // A pop in the push cycle frees a slot, so that push is not an overrun.
   assign overrun_set = push_strobe && fifo_full && !rd_en;

   always_ff @(posedge clk) begin
      if (rst) begin
         overrun_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         if (overrun_set) begin
            overrun_reg <= 1'b1;
         end else if (clr_err) begin
            overrun_reg <= 1'b0;
         end
         if (frame_err_set) begin
            frame_err_reg <= 1'b1;
         end else if (clr_err) begin
            frame_err_reg <= 1'b0;
         end
      end
   end

   assign overrun   = overrun_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_uart_rx_buf.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_buf
// Directed self-checking bench for uart_rx_buf with CLKS_PER_BIT = 4 and
// DEPTH = 4. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_uart_rx_buf;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       rxd;
   logic       rd_en;
   logic       clr_err;
   logic [7:0] rxdata;
   logic       rx_valid;
   logic [2:0] count;
   logic       overrun;
   logic       frame_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_buf #(
      .CLKS_PER_BIT (CPB),
      .DEPTH        (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rxd       (rxd),
      .rd_en     (rd_en),
      .clr_err   (clr_err),
      .rxdata    (rxdata),
      .rx_valid  (rx_valid),
      .count     (count),
      .overrun   (overrun),
      .frame_err (frame_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1 unit past the last one.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one 8N1 frame; returns 1 unit after the end of the stop bit with
   // the line back at idle. The push happens on the following edge.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit);
      $display("send frame 0x%02h stop=%0d", data, stop_bit);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = data[i];
         tick(CPB);
      end
      rxd = stop_bit;
      tick(CPB);
      rxd = 1'b1;
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      $display("pop 0x%02h", rxdata);
      check_eq(tag, 32'(rxdata), 32'(exp));
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   task automatic pulse_clr();
      $display("clr_err pulse");
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      rxd     = 1'b1;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(2);

      // Reset state
      check_eq("rst_valid",     32'(rx_valid),  32'h0);
      check_eq("rst_count",     32'(count),     32'h0);
      check_eq("rst_rxdata",    32'(rxdata),    32'h00);
      check_eq("rst_overrun",   32'(overrun),   32'h0);
      check_eq("rst_frame_err", 32'(frame_err), 32'h0);

      // Single frame 0x55: the stop sample lands 41 edges after the start
      // bit is driven (2 sync + 1 detect + 2 half bit + 8*4 data + 4 stop).
      send_frame(8'h55, 1'b1);
      check_eq("f55_valid_before", 32'(rx_valid), 32'h0);
      tick(1);
      check_eq("f55_valid_after",  32'(rx_valid), 32'h1);
      check_eq("f55_rxdata",       32'(rxdata),   32'h55);
      check_eq("f55_count",        32'(count),    32'h1);
      tick(6);
      pop_check("f55_pop", 8'h55);
      check_eq("f55_valid_empty",  32'(rx_valid), 32'h0);
      check_eq("f55_rxdata_empty", 32'(rxdata),   32'h00);
      check_eq("f55_count_empty",  32'(count),    32'h0);

      // Back-to-back frames with no idle gap
      send_frame(8'hA5, 1'b1);
      send_frame(8'h3C, 1'b1);
      send_frame(8'hFF, 1'b1);
      tick(4);
      check_eq("b2b_count", 32'(count), 32'h3);
      pop_check("b2b_pop0", 8'hA5);
      pop_check("b2b_pop1", 8'h3C);
      pop_check("b2b_pop2", 8'hFF);
      check_eq("b2b_count_end", 32'(count), 32'h0);

      // Overflow: five bytes into a four-deep FIFO
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1);
      end
      tick(4);
      check_eq("ovf_count",   32'(count),   32'h4);
      check_eq("ovf_overrun", 32'(overrun), 32'h1);
      pop_check("ovf_pop0", 8'h01);
      pop_check("ovf_pop1", 8'h02);
      pop_check("ovf_pop2", 8'h03);
      pop_check("ovf_pop3", 8'h04);
      check_eq("ovf_sticky", 32'(overrun), 32'h1);
      pulse_clr();
      check_eq("ovf_cleared", 32'(overrun), 32'h0);
      check_eq("ovf_count_end", 32'(count), 32'h0);

      // Full FIFO with a pop in the push cycle of 0x06
      for (int i = 0; i < 4; i++) begin
         send_frame(8'h11 + 8'(i), 1'b1);
      end
      tick(4);
      check_eq("fullpop_count_pre", 32'(count), 32'h4);
      send_frame(8'h06, 1'b1);
      $display("pop 0x%02h (same cycle as push)", rxdata);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      check_eq("fullpop_count",   32'(count),   32'h4);
      check_eq("fullpop_overrun", 32'(overrun), 32'h0);
      pop_check("fullpop_pop0", 8'h12);
      pop_check("fullpop_pop1", 8'h13);
      pop_check("fullpop_pop2", 8'h14);
      pop_check("fullpop_pop3", 8'h06);

      // Framing error: 0x81 with a low stop bit
      send_frame(8'h81, 1'b0);
      tick(8);
      check_eq("ferr_flag",  32'(frame_err), 32'h1);
      check_eq("ferr_count", 32'(count),     32'h0);
      check_eq("ferr_valid", 32'(rx_valid),  32'h0);
      pulse_clr();
      check_eq("ferr_cleared", 32'(frame_err), 32'h0);

      // One-cycle glitch on the idle line
      $display("glitch 1 cycle");
      rxd = 1'b0;
      tick(1);
      rxd = 1'b1;
      tick(20);
      check_eq("glitch_count",     32'(count),     32'h0);
      check_eq("glitch_frame_err", 32'(frame_err), 32'h0);
      check_eq("glitch_overrun",   32'(overrun),   32'h0);

      // Reset in the middle of the data bits of 0x7E, with one byte queued
      send_frame(8'h99, 1'b1);
      tick(4);
      check_eq("mid_rst_pre_count", 32'(count), 32'h1);
      $display("partial frame 0x7e then rst");
      rxd = 1'b0;
      tick(CPB);
      rxd = 1'b0;
      tick(CPB);
      rxd = 1'b1;
      tick(2);
      rst = 1'b1;
      rxd = 1'b1;
      tick(2);
      check_eq("mid_rst_valid",     32'(rx_valid),  32'h0);
      check_eq("mid_rst_count",     32'(count),     32'h0);
      check_eq("mid_rst_rxdata",    32'(rxdata),    32'h00);
      check_eq("mid_rst_overrun",   32'(overrun),   32'h0);
      check_eq("mid_rst_frame_err", 32'(frame_err), 32'h0);
      rst = 1'b0;
      tick(12);
      check_eq("post_rst_count", 32'(count), 32'h0);
      send_frame(8'h42, 1'b1);
      tick(3);
      check_eq("post_rst_valid",  32'(rx_valid), 32'h1);
      check_eq("post_rst_rxdata", 32'(rxdata),   32'h42);
      check_eq("post_rst_count1", 32'(count),    32'h1);
      pop_check("post_rst_pop", 8'h42);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per serial bit (100 MHz / 115200); legal values are 4 and above.
REQ-002 SHALL have parameter DEPTH, default 16, giving FIFO entries; it SHALL be a power of two, 2 or more.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rxd  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-007 rd_en  input  1  core pops the head byte; same-cycle consume.
REQ-008 clr_err  input  1  clears the sticky error flags.
REQ-009 rxdata  output  8  head byte of the FIFO; feeds the core rxdata input.
REQ-010 rx_valid  output  1  FIFO non-empty.
REQ-011 count  output  $clog2(DEPTH)+1  bytes currently held.
REQ-012 overrun  output  1  sticky: a byte was dropped because the FIFO was full.
REQ-013 frame_err  output  1  sticky: a frame had a low stop bit.

Function
REQ-014 rxd SHALL pass through a 2-flop synchronizer; both flops reset to 1; the FSM sees only the synchronized value.
REQ-015 The FSM SHALL have exactly four states: IDLE, START, DATA, STOP; each state uses one bit-timer counter and one 3-bit bit index.
REQ-016 IDLE: when synchronized rxd = 0, go to START and clear the timer.
REQ-017 START: at timer = CLKS_PER_BIT/2-1, sample. If rxd = 0, go to DATA and clear the timer. If rxd = 1, treat it as a glitch and return to IDLE with no push and no error.
REQ-018 DATA: at timer = CLKS_PER_BIT-1, sample rxd into shift-register bit[index] (LSB first). After index 7 is sampled, go to STOP.
REQ-019 STOP: at timer = CLKS_PER_BIT-1, sample (mid stop bit) and return to IDLE the same cycle, so back-to-back frames are accepted.
  - rxd = 1: assert the push strobe for one cycle.
  - rxd = 0: set frame_err and discard the byte.
REQ-020 The FIFO SHALL be first-word-fall-through.
  - rxdata = mem[rd_ptr] whenever rx_valid = 1.
  - rxdata = 8'h00 when empty.
REQ-021 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap naturally.
  - empty: pointers equal.
  - full: MSBs differ, remaining bits equal.
REQ-022 Push latency: the byte SHALL be visible (rx_valid = 1 if previously empty) in the cycle after the stop-bit sample edge.
REQ-023 rd_en while empty SHALL be ignored; pointers and count are unchanged.
REQ-024 Simultaneous push and pop SHALL both take effect with count unchanged, including when full (the pop frees the slot).
REQ-025 Push while full without pop SHALL drop the byte and set overrun; stored data is unchanged.
REQ-026 clr_err SHALL clear overrun and frame_err next cycle; a same-cycle set event SHALL win over clr_err.
REQ-027 The core SHALL observe only rxdata, rx_valid and the flags; no combinational path from rxd to any output.

Reset
REQ-028 On rst:
  - FSM goes to IDLE; timer, index, shift register and pointers go to 0.
  - rx_valid = 0, count = 0, rxdata = 8'h00, overrun = 0, frame_err = 0.
  - Synchronizer flops go to 1.
REQ-029 rst mid-frame SHALL abandon the frame with no push. Reception restarts on the next falling edge after rst deasserts.
REQ-030 FIFO contents are not cleared by rst; only the pointers are.

Structure
REQ-031 Package uart_pkg SHALL hold:
  - the FSM state enum (rx_state_t: IDLE, START, DATA, STOP);
  - constants DEFAULT_CLKS_PER_BIT = 868 and DEFAULT_RX_DEPTH = 16.
REQ-032 The FIFO SHALL be a sub-module fifo_sync, parameterized by WIDTH and DEPTH, with ports:
  - inputs push, pop, din;
  - outputs dout, empty, full, count.
  It is reusable for a future tx buffer.
REQ-033 uart_rx_buf SHALL contain the synchronizer, the FSM and the flag logic, plus one fifo_sync instance.

Verification (CLKS_PER_BIT = 4, DEPTH = 4)
REQ-034 Send frame 0x55, then idle. Required: rx_valid rises the cycle after the stop sample, rxdata = 0x55, count = 1. Pulse rd_en: rx_valid = 0, rxdata = 0x00.
REQ-035 Send 0xA5, 0x3C, 0xFF back-to-back with no idle gap. Required: count = 3 and pops return 0xA5, 0x3C, 0xFF in order.
REQ-036 Send 5 bytes 0x01 to 0x05 with no pops. Required: count = 4, overrun = 1, bytes read back are 0x01 to 0x04. Pulse clr_err: overrun = 0.
REQ-037 With the FIFO full, assert rd_en in the cycle of the 0x06 push. Required: count stays 4, overrun stays 0, 0x06 is the last entry.
REQ-038 Check both error cases:
  - Frame 0x81 with stop bit driven 0: frame_err = 1, count unchanged.
  - 1-cycle low glitch on idle rxd: no push, no error.
REQ-039 Assert rst during DATA of 0x7E. Required: all outputs at reset values. A following clean 0x42 frame is received correctly.
